number_hit_detector: RTL and testbench

//  Upstream stage of the score controller. Collects per-pixel collisions between the player

---
 rtl/number_hit_detector.sv | 134 +++++++++++++
 tb/tb_number_hit_detector.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/number_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : number_hit_detector
// Brief    : Collects player/number and player/operand pixel collisions over a
//            frame. Emits one operand pulse and then one number pulse after each
//            frame boundary. A number that was hit stays hidden for a respawn
//            period.
// Revision : 1.0 - initial release
// ============================================================================
module number_hit_detector #(
    parameter int NUMBERS        = 9,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               playerDrawingRequest,
    input  logic [NUMBERS-1:0] numberDrawingRequest,
    input  logic [1:0]         operandDrawingRequest,
    output logic [NUMBERS-1:0] SingleHitPulse,
    output logic [1:0]         operandHit,
    output logic [NUMBERS-1:0] numberVisible
);

    localparam int            CW        = $clog2(RESPAWN_FRAMES + 1);
    localparam logic [CW-1:0] C_RESPAWN = CW'(RESPAWN_FRAMES);

    typedef enum logic [1:0] {
        S_COLLECT   = 2'd0,
        S_EVAL      = 2'd1,
        S_OP_PULSE  = 2'd2,
        S_NUM_PULSE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [NUMBERS-1:0] r_num_hit;
    logic [NUMBERS-1:0] r_eval_num;
    logic [NUMBERS-1:0] w_num_contact;
    logic [NUMBERS-1:0] w_num_lowest;
    logic [1:0]         r_op_hit;
    logic [1:0]         r_eval_op;
    logic [1:0]         r_prev_op;
    logic [1:0]         w_op_contact;
    logic [1:0]         w_op_edge;
    logic [CW-1:0]      r_cnt [NUMBERS];

    // Contacts on the current pixel; hidden numbers cannot be hit.
    assign w_num_contact = {NUMBERS{playerDrawingRequest}} & numberDrawingRequest & numberVisible;
    assign w_op_contact  = {2{playerDrawingRequest}} & operandDrawingRequest;

    // Only a fresh touch (not held from the previous frame) counts.
    assign w_op_edge    = r_eval_op & ~r_prev_op;
    // Isolate the lowest set bit: lowest index number wins.
    assign w_num_lowest = r_eval_num & (~r_eval_num + NUMBERS'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and pulse outputs; pulses are suppressed while the game is inactive.
    always_comb begin
        w_state_next   = r_state;
        operandHit     = 2'b00;
        SingleHitPulse = '0;
        case (r_state)
            S_COLLECT:   if (startOfFrame) w_state_next = S_EVAL;
            S_EVAL:      w_state_next = S_OP_PULSE;
            S_OP_PULSE: begin
                w_state_next = S_NUM_PULSE;
                if (enable) begin
                    if (w_op_edge[0])      operandHit = 2'b01;
                    else if (w_op_edge[1]) operandHit = 2'b10;
                end
            end
            S_NUM_PULSE: begin
                w_state_next = S_COLLECT;
                if (enable) SingleHitPulse = w_num_lowest;
            end
            default:     w_state_next = S_COLLECT;
        endcase
    end

    // Sticky collision flags; at EVAL they are snapshotted and restart with the current pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_hit  <= '0;
            r_op_hit   <= 2'b00;
            r_eval_num <= '0;
            r_eval_op  <= 2'b00;
            r_prev_op  <= 2'b00;
        end else begin
            if (r_state == S_EVAL) begin
                r_eval_num <= r_num_hit;
                r_eval_op  <= r_op_hit;
                r_num_hit  <= w_num_contact;
                r_op_hit   <= w_op_contact;
            end else begin
                r_num_hit  <= r_num_hit | w_num_contact;
                r_op_hit   <= r_op_hit | w_op_contact;
            end
            // Updated even when disabled so re-enabling does not replay a held touch.
            if (r_state == S_OP_PULSE) begin
                r_prev_op <= r_eval_op;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUMBERS; gi++) begin : g_respawn
            // Respawn counter: loaded on a scored hit, counts frame boundaries down to zero.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (SingleHitPulse[gi]) begin
                    r_cnt[gi] <= C_RESPAWN;
                end else if ((r_state == S_EVAL) && (r_cnt[gi] != '0)) begin
                    r_cnt[gi] <= r_cnt[gi] - CW'(1);
                end
            end

            assign numberVisible[gi] = (r_cnt[gi] == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_number_hit_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_number_hit_detector
// Brief    : Directed, table-driven self-checking bench for number_hit_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_number_hit_detector;

    logic       clk;
    logic       reset;
    logic       startOfFrame;
    logic       enable;
    logic       playerDrawingRequest;
    logic [8:0] numberDrawingRequest;
    logic [1:0] operandDrawingRequest;
    logic [8:0] SingleHitPulse;
    logic [1:0] operandHit;
    logic [8:0] numberVisible;

    int n_pass;
    int n_total;

    number_hit_detector #(
        .NUMBERS        (9),
        .RESPAWN_FRAMES (120)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .startOfFrame          (startOfFrame),
        .enable                (enable),
        .playerDrawingRequest  (playerDrawingRequest),
        .numberDrawingRequest  (numberDrawingRequest),
        .operandDrawingRequest (operandDrawingRequest),
        .SingleHitPulse        (SingleHitPulse),
        .operandHit            (operandHit),
        .numberVisible         (numberVisible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       pl;
        logic [8:0] nr;
        logic [1:0] orq;
        logic [1:0] eop;
        logic [8:0] enm;
        logic [8:0] vis;
    } vec_t;

    vec_t tbl [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One frame: 10 cycles of contact, then a frame boundary and checks on the 4 cycles after it.
    task automatic do_frame(input logic en, input logic pl, input logic [8:0] nr,
                            input logic [1:0] orq, input logic [1:0] eop,
                            input logic [8:0] enm, input logic [8:0] vis, input string tag);
        enable                = en;
        playerDrawingRequest  = pl;
        numberDrawingRequest  = nr;
        operandDrawingRequest = orq;
        repeat (10) tick();
        playerDrawingRequest  = 1'b0;
        numberDrawingRequest  = '0;
        operandDrawingRequest = 2'b00;
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check({tag, " sof+1 pulses"}, {5'd0, operandHit, 2'b00} | SingleHitPulse, 9'h000);
        tick();
        check({tag, " sof+2 op"},  {7'd0, operandHit}, {7'd0, eop});
        check({tag, " sof+2 num"}, SingleHitPulse, 9'h000);
        tick();
        check({tag, " sof+3 num"}, SingleHitPulse, enm);
        check({tag, " sof+3 op"},  {7'd0, operandHit}, 9'h000);
        tick();
        check({tag, " sof+4 pulses"}, {5'd0, operandHit, 2'b00} | SingleHitPulse, 9'h000);
        check({tag, " sof+4 visible"}, numberVisible, vis);
    endtask

    initial begin
        logic [8:0] acc;
        n_pass  = 0;
        n_total = 0;

        //           en    pl    nr      orq    eop    enm     vis
        tbl[0]  = '{1'b1, 1'b1, 9'h010, 2'b00, 2'b00, 9'h010, 9'h1EF};
        tbl[1]  = '{1'b1, 1'b1, 9'h044, 2'b00, 2'b00, 9'h004, 9'h1EB};
        tbl[2]  = '{1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000, 9'h1EB};
        tbl[3]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b01, 9'h000, 9'h1EB};
        tbl[4]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b00, 9'h000, 9'h1EB};
        tbl[5]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b00, 9'h000, 9'h1EB};
        tbl[6]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b00, 9'h000, 9'h1EB};
        tbl[7]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b00, 9'h000, 9'h1EB};
        tbl[8]  = '{1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000, 9'h1EB};
        tbl[9]  = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b01, 9'h000, 9'h1EB};
        tbl[10] = '{1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000, 9'h1EB};
        tbl[11] = '{1'b1, 1'b1, 9'h001, 2'b11, 2'b01, 9'h001, 9'h1EA};
        tbl[12] = '{1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000, 9'h1EA};
        tbl[13] = '{1'b1, 1'b1, 9'h000, 2'b10, 2'b10, 9'h000, 9'h1EA};
        tbl[14] = '{1'b1, 1'b1, 9'h008, 2'b00, 2'b00, 9'h008, 9'h1E2};
        tbl[15] = '{1'b1, 1'b1, 9'h008, 2'b00, 2'b00, 9'h000, 9'h1E2};
        tbl[16] = '{1'b0, 1'b1, 9'h020, 2'b01, 2'b00, 9'h000, 9'h1E2};
        tbl[17] = '{1'b1, 1'b1, 9'h000, 2'b01, 2'b00, 9'h000, 9'h1E2};
        tbl[18] = '{1'b1, 1'b1, 9'h020, 2'b00, 2'b00, 9'h020, 9'h1C2};
        tbl[19] = '{1'b1, 1'b0, 9'h100, 2'b01, 2'b00, 9'h000, 9'h1C2};
        tbl[20] = '{1'b1, 1'b1, 9'h1FF, 2'b00, 2'b00, 9'h002, 9'h1C0};

        reset                 = 1'b1;
        startOfFrame          = 1'b0;
        enable                = 1'b1;
        playerDrawingRequest  = 1'b0;
        numberDrawingRequest  = '0;
        operandDrawingRequest = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        check("reset visible", numberVisible, 9'h1FF);
        check("reset pulses", {5'd0, operandHit, 2'b00} | SingleHitPulse, 9'h000);

        for (int i = 0; i < 21; i++) begin
            do_frame(tbl[i].en, tbl[i].pl, tbl[i].nr, tbl[i].orq,
                     tbl[i].eop, tbl[i].enm, tbl[i].vis, $sformatf("vec%0d", i));
        end

        // Reset arriving in the operand-pulse cycle aborts the pending number pulse.
        enable                = 1'b1;
        playerDrawingRequest  = 1'b1;
        numberDrawingRequest  = 9'h001;
        operandDrawingRequest = 2'b01;
        repeat (3) tick();
        playerDrawingRequest  = 1'b0;
        numberDrawingRequest  = '0;
        operandDrawingRequest = 2'b00;
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        check("midreset op before", {7'd0, operandHit}, 9'h001);
        reset = 1'b1;
        tick();
        check("midreset pulses", {5'd0, operandHit, 2'b00} | SingleHitPulse, 9'h000);
        check("midreset visible", numberVisible, 9'h1FF);
        reset = 1'b0;
        acc   = '0;
        repeat (4) begin
            tick();
            acc = acc | SingleHitPulse | {5'd0, operandHit, 2'b00};
        end
        check("midreset no late pulse", acc, 9'h000);
        do_frame(1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000, 9'h1FF, "post_reset idle");
        do_frame(1'b1, 1'b1, 9'h001, 2'b01, 2'b01, 9'h001, 9'h1FE, "post_reset hit");

        // Full respawn period for number 4.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_frame(1'b1, 1'b1, 9'h010, 2'b00, 2'b00, 9'h010, 9'h1EF, "respawn hit");
        for (int k = 1; k <= 120; k++) begin
            do_frame(1'b1, 1'b0, 9'h000, 2'b00, 2'b00, 9'h000,
                     (k == 120) ? 9'h1FF : 9'h1EF, $sformatf("respawn f%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
